// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR saturate-and-pack output stage.
package fir_pkg;

  localparam int Q15_MAX = 32767;
  localparam int Q15_MIN = -32768;

  typedef logic signed [15:0] q15_t;

  // Two Q1.15 samples per output word; the older sample sits in the low half.
  typedef struct packed {
    q15_t hi;
    q15_t lo;
  } pword_t;

  // One FIFO entry: the packed word plus its end-of-frame marker.
  typedef struct packed {
    logic   last;
    pword_t word;
  } fifo_ent_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO. A write into a full FIFO is still taken when a read
// happens in the same cycle, because that read frees the slot being written.
module sync_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_wr, do_rd;

  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // The extra pointer MSB tells full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Storage: data only, no reset needed since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Pointer update.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fir_sat_pack.sv
// Saturates decimated FIR results to Q1.15, packs pairs into 32-bit words,
// frames them with tlast and buffers them for an AXI-Stream-style consumer.
module fir_sat_pack
  import fir_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int FRAME_BEATS = 64,
  parameter int IN_WIDTH    = 32
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       s_tvalid,
  input  logic signed [IN_WIDTH-1:0] s_tdata,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [31:0]                m_tdata,
  output logic                       m_tlast,
  input  logic                       clr_status,
  output logic                       overflow,
  output logic [15:0]                sat_count
);

  localparam int BW = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam logic signed [IN_WIDTH-1:0] MAXW = IN_WIDTH'(Q15_MAX);
  localparam logic signed [IN_WIDTH-1:0] MINW = IN_WIDTH'(Q15_MIN);

  logic          over, under, clip;
  q15_t          sat_val, half;
  logic          phase;
  logic [BW-1:0] beat;
  logic          push, pop, full, empty, drop, tlast_in;
  fifo_ent_t     wr_ent, rd_ent;

  assign over    = (s_tdata > MAXW);
  assign under   = (s_tdata < MINW);
  assign clip    = s_tvalid && (over || under);
  assign sat_val = over ? 16'sh7FFF : (under ? 16'sh8000 : s_tdata[15:0]);

  // Phase 1 means a low half is waiting, so this sample completes a word.
  assign push     = s_tvalid && phase;
  assign pop      = m_tvalid && m_tready;
  assign drop     = push && full && !pop;
  assign tlast_in = (beat == BW'(FRAME_BEATS - 1));

  assign wr_ent.last    = tlast_in;
  assign wr_ent.word.hi = sat_val;
  assign wr_ent.word.lo = half;

  sync_fifo #(
    .W     ($bits(fifo_ent_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .nrst    (nrst),
    .wr_en   (push),
    .wr_data (wr_ent),
    .rd_en   (pop),
    .rd_data (rd_ent),
    .full    (full),
    .empty   (empty)
  );

  // Head entry is exposed directly; zeroed while empty so idle/reset outputs are clean.
  assign m_tvalid = !empty;
  assign m_tdata  = empty ? 32'd0 : rd_ent.word;
  assign m_tlast  = empty ? 1'b0  : rd_ent.last;

  // Pairing: hold the first sample, toggle phase on every strobe regardless of drops.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      phase <= 1'b0;
      half  <= '0;
    end else if (s_tvalid) begin
      phase <= ~phase;
      if (!phase) half <= sat_val;
    end
  end

  // Beat counter advances only for words the FIFO actually took.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      beat <= '0;
    end else if (push && !drop) begin
      beat <= tlast_in ? '0 : beat + 1'b1;
    end
  end

  // Status: a same-cycle event beats the clear, leaving the freshly-set value.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      overflow  <= 1'b0;
      sat_count <= '0;
    end else begin
      if (drop)            overflow <= 1'b1;
      else if (clr_status) overflow <= 1'b0;

      if (clip) begin
        if (clr_status)                sat_count <= 16'd1;
        else if (sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
      end else if (clr_status) begin
        sat_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fir_sat_pack.sv
// Bench for fir_sat_pack: directed samples, expected words queued at issue,
// a negedge monitor pops and compares whenever a beat is transferred.
module tb_fir_sat_pack;
  localparam int DEPTH = 16;
  localparam int FB    = 64;

  logic               clk = 1'b0;
  logic               nrst;
  logic               s_tvalid;
  logic signed [31:0] s_tdata;
  logic               m_tvalid, m_tready, m_tlast;
  logic [31:0]        m_tdata;
  logic               clr_status, overflow;
  logic [15:0]        sat_count;

  int pass_cnt = 0;
  int total    = 0;
  logic [32:0] sb [$];   // {last, data}

  fir_sat_pack #(.FIFO_DEPTH(DEPTH), .FRAME_BEATS(FB), .IN_WIDTH(32)) dut (
    .clk(clk), .nrst(nrst), .s_tvalid(s_tvalid), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .clr_status(clr_status), .overflow(overflow), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every transferred beat must match the oldest expectation.
  always @(negedge clk) begin
    if (nrst && m_tvalid && m_tready) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_beat: got %0h expected none", m_tdata);
      end else begin
        logic [32:0] e;
        e = sb.pop_front();
        chk("beat", {31'd0, m_tlast, m_tdata}, {31'd0, e});
      end
    end
  end

  task automatic send(input int v);
    s_tvalid = 1'b1;
    s_tdata  = v;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic expect_word(input logic [31:0] d, input logic l);
    sb.push_back({l, d});
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    m_tready = 1'b1;
    while ((sb.size() != 0 || m_tvalid) && n < 2000) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    chk({name, "_drained"}, {63'd0, (sb.size() == 0 && !m_tvalid)}, 64'd1);
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    nrst = 1'b0; s_tvalid = 1'b0; s_tdata = 0; m_tready = 1'b0; clr_status = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_tvalid", {63'd0, m_tvalid}, 64'd0);
    chk("rst_tdata",  {32'd0, m_tdata},  64'd0);
    chk("rst_tlast",  {63'd0, m_tlast},  64'd0);
    chk("rst_ovf",    {63'd0, overflow}, 64'd0);
    chk("rst_sat",    {48'd0, sat_count}, 64'd0);
    nrst = 1'b1;
    @(posedge clk); #1;

    // Basic pack and one-cycle latency.
    m_tready = 1'b1;
    expect_word(32'hFF38_0064, 1'b0);
    send(100);
    send(-200);
    @(negedge clk);
    chk("latency_tvalid", {63'd0, m_tvalid}, 64'd1);
    drain("basic");

    // Saturation both directions.
    expect_word(32'h8000_7FFF, 1'b0);
    send(40000);
    send(-40000);
    @(negedge clk);
    chk("sat_count2", {48'd0, sat_count}, 64'd2);
    drain("sat");

    // Clear coincident with a clip: clip wins, count restarts at 1.
    expect_word(32'h0000_7FFF, 1'b0);
    clr_status = 1'b1;
    send(70000);
    clr_status = 1'b0;
    @(negedge clk);
    chk("clr_with_clip", {48'd0, sat_count}, 64'd1);
    send(0);
    clr_status = 1'b1;
    @(posedge clk); #1;
    clr_status = 1'b0;
    @(negedge clk);
    chk("clr_alone", {48'd0, sat_count}, 64'd0);
    drain("clr");

    // Overflow: 2*DEPTH+2 samples with no ready; last word dropped.
    m_tready = 1'b0;
    for (int j = 0; j < 2*DEPTH+2; j++) begin
      if (j % 2 == 1 && j / 2 < DEPTH)
        expect_word({16'(j), 16'(j-1)}, 1'b0);
      send(j);
    end
    @(negedge clk);
    chk("ovf_set", {63'd0, overflow}, 64'd1);
    chk("ovf_head", {32'd0, m_tdata}, 64'h0000_0001_0000);
    repeat (3) @(negedge clk);
    chk("ovf_head_stable", {32'd0, m_tdata}, 64'h0000_0001_0000);
    drain("ovf");
    clr_status = 1'b1;
    @(posedge clk); #1;
    clr_status = 1'b0;
    @(negedge clk);
    chk("ovf_clr", {63'd0, overflow}, 64'd0);

    // Framing: fresh counter, 2*FB beats, tlast on beat FB-1 and 2*FB-1.
    do_reset();
    m_tready = 1'b1;
    for (int k = 0; k < 2*FB; k++) begin
      expect_word({16'((2*k+1) & 16'h7FFF), 16'((2*k) & 16'h7FFF)}, (k == FB-1) || (k == 2*FB-1));
      send((2*k) & 16'h7FFF);
      send((2*k+1) & 16'h7FFF);
    end
    drain("frame");

    // Reset mid-pair: pending half discarded.
    send(5);
    nrst = 1'b0;
    @(negedge clk);
    chk("midrst_tvalid", {63'd0, m_tvalid}, 64'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk); #1;
    expect_word(32'h0009_0007, 1'b0);
    send(7);
    send(9);
    drain("midrst");

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
